// File: rtl/scoreboard_pkg.sv
// Shared definitions for the writeback scoreboard: FSM encodings, defaults and width helpers.
package scoreboard_pkg;

    typedef logic [1:0] sb_state_t;

    localparam sb_state_t st_idle = 2'd0;
    localparam sb_state_t st_run  = 2'd1;
    localparam sb_state_t st_done = 2'd2;

    localparam int unsigned def_data_width     = 64;
    localparam int unsigned def_reg_addr_width = 5;
    localparam int unsigned def_depth          = 16;
    localparam int unsigned def_timeout        = 64;
    localparam int unsigned def_zero_reg       = 31;

    localparam int unsigned def_ptr_width = $clog2(def_depth);
    localparam int unsigned def_cnt_width = def_ptr_width + 1;

    // Counters must hold the value DEPTH itself, hence one extra bit over the index.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sb_expect_mem.sv
// Expected-writeback list: one synchronous write port, one combinational read port.
module sb_expect_mem #(
    parameter int unsigned WIDTH = 69,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // No reset: the list survives a scoreboard reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/wb_scoreboard.sv
// In-order register-writeback checker: compares snooped RegWrite traffic against a preloaded list.
module wb_scoreboard
    import scoreboard_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = def_data_width,
    parameter int unsigned REG_ADDR_WIDTH = def_reg_addr_width,
    parameter int unsigned DEPTH          = def_depth,
    parameter int unsigned TIMEOUT        = def_timeout,
    parameter int unsigned ZERO_REG       = def_zero_reg
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         exp_we,
    input  logic [$clog2(DEPTH)-1:0]     exp_addr,
    input  logic [REG_ADDR_WIDTH-1:0]    exp_reg,
    input  logic [DATA_WIDTH-1:0]        exp_data,
    input  logic [$clog2(DEPTH):0]       exp_count,
    input  logic                         start,
    input  logic                         wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0]    wb_reg,
    input  logic [DATA_WIDTH-1:0]        wb_data,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic                         timeout,
    output logic [$clog2(DEPTH):0]       match_count,
    output logic [$clog2(DEPTH):0]       error_count,
    output logic [$clog2(DEPTH)-1:0]     fail_index,
    output logic [DATA_WIDTH-1:0]        fail_data
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = cnt_width(DEPTH);
    localparam int unsigned ENTRY_W = REG_ADDR_WIDTH + DATA_WIDTH;
    localparam int unsigned WD_W    = $clog2(TIMEOUT) + 1;

    localparam logic [CNT_W-1:0]          cnt_max  = CNT_W'(DEPTH);
    localparam logic [WD_W-1:0]           wd_limit = WD_W'(TIMEOUT - 1);
    localparam logic [REG_ADDR_WIDTH-1:0] zero_reg = REG_ADDR_WIDTH'(ZERO_REG);

    sb_state_t              state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [CNT_W-1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0]       match_q, match_d;
    logic [CNT_W-1:0]       error_q, error_d;
    logic [PTR_W-1:0]       fail_index_q, fail_index_d;
    logic [DATA_WIDTH-1:0]  fail_data_q, fail_data_d;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic                   timeout_q, timeout_d;
    logic                   busy_q, done_q, pass_q;
    logic                   pass_d;

    logic                   accept;
    logic                   mem_we;
    logic [ENTRY_W-1:0]     exp_entry;
    logic [CNT_W-1:0]       ptr_inc;

    assign mem_we = exp_we && (state_q != st_run);

    sb_expect_mem #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_expect_mem (
        .clock (clock),
        .we    (mem_we),
        .waddr (exp_addr),
        .wdata ({exp_reg, exp_data}),
        .raddr (ptr_q[PTR_W-1:0]),
        .rdata (exp_entry)
    );

    assign accept  = (state_q == st_run) && wb_valid && (wb_reg != zero_reg);
    assign ptr_inc = ptr_q + CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        ptr_d        = ptr_q;
        match_d      = match_q;
        error_d      = error_q;
        fail_index_d = fail_index_q;
        fail_data_d  = fail_data_q;
        wd_d         = wd_q;
        timeout_d    = timeout_q;

        case (state_q)
            st_idle, st_done: begin
                if (start) begin
                    state_d      = st_run;
                    count_d      = (exp_count > cnt_max) ? cnt_max : exp_count;
                    ptr_d        = '0;
                    match_d      = '0;
                    error_d      = '0;
                    fail_index_d = '0;
                    fail_data_d  = '0;
                    wd_d         = '0;
                    timeout_d    = 1'b0;
                end
            end
            st_run: begin
                if (ptr_q == count_q) begin
                    // Only reachable for an empty list.
                    state_d = st_done;
                end else if (accept) begin
                    if ({wb_reg, wb_data} == exp_entry) begin
                        if (match_q != cnt_max) match_d = match_q + CNT_W'(1);
                    end else begin
                        if (error_q == '0) begin
                            fail_index_d = ptr_q[PTR_W-1:0];
                            fail_data_d  = wb_data;
                        end
                        if (error_q != cnt_max) error_d = error_q + CNT_W'(1);
                    end
                    ptr_d = ptr_inc;
                    wd_d  = '0;
                    if (ptr_inc == count_q) state_d = st_done;
                end else if (wd_q == wd_limit) begin
                    timeout_d = 1'b1;
                    state_d   = st_done;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: state_d = st_idle;
        endcase

        pass_d = (state_d == st_done) && (error_d == '0) && !timeout_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= st_idle;
            count_q      <= '0;
            ptr_q        <= '0;
            match_q      <= '0;
            error_q      <= '0;
            fail_index_q <= '0;
            fail_data_q  <= '0;
            wd_q         <= '0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            ptr_q        <= ptr_d;
            match_q      <= match_d;
            error_q      <= error_d;
            fail_index_q <= fail_index_d;
            fail_data_q  <= fail_data_d;
            wd_q         <= wd_d;
            timeout_q    <= timeout_d;
            busy_q       <= (state_d == st_run);
            done_q       <= (state_d == st_done);
            pass_q       <= pass_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign match_count = match_q;
    assign error_count = error_q;
    assign fail_index  = fail_index_q;
    assign fail_data   = fail_data_q;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Directed bench for wb_scoreboard using the R-type X2 writeback sequence.
module tb_wb_scoreboard;

    logic        clock = 1'b0;
    logic        reset;
    logic        exp_we;
    logic [3:0]  exp_addr;
    logic [4:0]  exp_reg;
    logic [63:0] exp_data;
    logic [4:0]  exp_count;
    logic        start;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [63:0] wb_data;
    logic        busy, done, pass, timeout;
    logic [4:0]  match_count, error_count;
    logic [3:0]  fail_index;
    logic [63:0] fail_data;

    int checks = 0;
    int errors = 0;

    // X2 results of the R-type program with X16=20, X18=6, X17=8.
    int xval [7] = '{26, 14, 4, 22, 18, 160, 2};

    wb_scoreboard dut (
        .clock       (clock),
        .reset       (reset),
        .exp_we      (exp_we),
        .exp_addr    (exp_addr),
        .exp_reg     (exp_reg),
        .exp_data    (exp_data),
        .exp_count   (exp_count),
        .start       (start),
        .wb_valid    (wb_valid),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .match_count (match_count),
        .error_count (error_count),
        .fail_index  (fail_index),
        .fail_data   (fail_data)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input int idx, input int r, input int d);
        exp_we   = 1'b1;
        exp_addr = 4'(idx);
        exp_reg  = 5'(r);
        exp_data = 64'(d);
        tick();
        exp_we   = 1'b0;
    endtask

    task automatic pulse_start(input int n);
        exp_count = 5'(n);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wb(input int r, input int d);
        wb_valid = 1'b1;
        wb_reg   = 5'(r);
        wb_data  = 64'(d);
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, done, pass, timeout} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000", {busy, done, pass, timeout});
        end
        checks++;
        if ({match_count, error_count, fail_index} !== 14'd0 || fail_data !== 64'd0) begin
            errors++;
            $display("FAIL reset_counts: got m=%0d e=%0d fi=%0d fd=%0d want all 0",
                     match_count, error_count, fail_index, fail_data);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_match();
        for (int i = 0; i < 7; i++) load(i, 2, xval[i]);
        pulse_start(7);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL match_busy: got %b want 1", busy);
        end
        for (int i = 0; i < 6; i++) wb(2, xval[i]);
        checks++;
        if (done !== 1'b0 || match_count !== 5'd6) begin
            errors++;
            $display("FAIL match_partial: got done=%b m=%0d want done=0 m=6", done, match_count);
        end
        wb(2, xval[6]);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || match_count !== 5'd7 || pass !== 1'b1) begin
            errors++;
            $display("FAIL match_final: got done=%b busy=%b m=%0d pass=%b want 1 0 7 1",
                     done, busy, match_count, pass);
        end
    endtask

    task automatic test_mismatch();
        load(2, 2, 5);
        pulse_start(7);
        for (int i = 0; i < 7; i++) wb(2, xval[i]);
        checks++;
        if (error_count !== 5'd1 || fail_index !== 4'd2 || fail_data !== 64'd4) begin
            errors++;
            $display("FAIL mismatch_capture: got e=%0d fi=%0d fd=%0d want 1 2 4",
                     error_count, fail_index, fail_data);
        end
        checks++;
        if (pass !== 1'b0 || match_count !== 5'd6 || done !== 1'b1) begin
            errors++;
            $display("FAIL mismatch_result: got pass=%b m=%0d done=%b want 0 6 1",
                     pass, match_count, done);
        end
        // Second mismatch at index 5 must not overwrite the first capture.
        pulse_start(7);
        for (int i = 0; i < 7; i++) wb(2, (i == 5) ? 17 : xval[i]);
        checks++;
        if (error_count !== 5'd2 || fail_index !== 4'd2 || fail_data !== 64'd4
            || match_count !== 5'd5) begin
            errors++;
            $display("FAIL mismatch_first_only: got e=%0d fi=%0d fd=%0d m=%0d want 2 2 4 5",
                     error_count, fail_index, fail_data, match_count);
        end
        load(2, 2, 4);
    endtask

    task automatic test_timeout();
        pulse_start(3);
        wb(2, 26);
        for (int i = 0; i < 63; i++) tick();
        checks++;
        if (timeout !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: got to=%b done=%b want 0 0", timeout, done);
        end
        tick();
        checks++;
        if (timeout !== 1'b1 || done !== 1'b1 || match_count !== 5'd1 || pass !== 1'b0) begin
            errors++;
            $display("FAIL timeout_fire: got to=%b done=%b m=%0d pass=%b want 1 1 1 0",
                     timeout, done, match_count, pass);
        end
    endtask

    task automatic test_timeout_boundary();
        // A write in the would-expire cycle wins over the watchdog.
        pulse_start(3);
        for (int i = 0; i < 63; i++) tick();
        wb(2, 26);
        checks++;
        if (timeout !== 1'b0 || busy !== 1'b1 || match_count !== 5'd1) begin
            errors++;
            $display("FAIL timeout_boundary: got to=%b busy=%b m=%0d want 0 1 1",
                     timeout, busy, match_count);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_ignored();
        wb(2, 26);
        wb(2, 999);
        pulse_start(7);
        for (int i = 0; i < 7; i++) begin
            wb(31, 12345);
            wb(2, xval[i]);
        end
        checks++;
        if (match_count !== 5'd7 || error_count !== 5'd0 || pass !== 1'b1) begin
            errors++;
            $display("FAIL ignored_writes: got m=%0d e=%0d pass=%b want 7 0 1",
                     match_count, error_count, pass);
        end
    endtask

    task automatic test_reset_mid();
        pulse_start(7);
        for (int i = 0; i < 3; i++) wb(2, xval[i]);
        checks++;
        if (match_count !== 5'd3) begin
            errors++;
            $display("FAIL reset_mid_before: got m=%0d want 3", match_count);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || match_count !== 5'd0) begin
            errors++;
            $display("FAIL reset_mid_cleared: got busy=%b done=%b m=%0d want 0 0 0",
                     busy, done, match_count);
        end
        pulse_start(7);
        for (int i = 0; i < 7; i++) wb(2, xval[i]);
        checks++;
        if (pass !== 1'b1 || match_count !== 5'd7) begin
            errors++;
            $display("FAIL reset_mid_rerun: got pass=%b m=%0d want 1 7", pass, match_count);
        end
    endtask

    task automatic test_zero_count();
        pulse_start(0);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL zero_first: got busy=%b done=%b want 1 0", busy, done);
        end
        tick();
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || match_count !== 5'd0) begin
            errors++;
            $display("FAIL zero_done: got done=%b pass=%b m=%0d want 1 1 0",
                     done, pass, match_count);
        end
    endtask

    task automatic test_run_ignores();
        pulse_start(7);
        wb(2, xval[0]);
        wb(2, xval[1]);
        // Neither a restart nor a list edit may take effect mid-run.
        pulse_start(1);
        load(5, 7, 77);
        for (int i = 2; i < 6; i++) wb(2, xval[i]);
        checks++;
        if (done !== 1'b0 || match_count !== 5'd6) begin
            errors++;
            $display("FAIL run_start_ignored: got done=%b m=%0d want 0 6", done, match_count);
        end
        wb(2, xval[6]);
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || match_count !== 5'd7) begin
            errors++;
            $display("FAIL run_we_ignored: got done=%b pass=%b m=%0d want 1 1 7",
                     done, pass, match_count);
        end
    endtask

    task automatic test_clamp();
        for (int i = 7; i < 16; i++) load(i, 3, i * 3);
        pulse_start(20);
        for (int i = 0; i < 15; i++) wb((i < 7) ? 2 : 3, (i < 7) ? xval[i] : i * 3);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL clamp_early: got done=%b want 0", done);
        end
        wb(3, 45);
        checks++;
        if (done !== 1'b1 || match_count !== 5'd16 || pass !== 1'b1) begin
            errors++;
            $display("FAIL clamp_final: got done=%b m=%0d pass=%b want 1 16 1",
                     done, match_count, pass);
        end
    endtask

    initial begin
        reset     = 1'b1;
        exp_we    = 1'b0;
        exp_addr  = '0;
        exp_reg   = '0;
        exp_data  = '0;
        exp_count = '0;
        start     = 1'b0;
        wb_valid  = 1'b0;
        wb_reg    = '0;
        wb_data   = '0;

        test_reset();
        test_match();
        test_mismatch();
        test_timeout();
        test_timeout_boundary();
        test_ignored();
        test_reset_mid();
        test_zero_count();
        test_run_ignores();
        test_clamp();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
